// File: rtl/player_bullet.sv
// player_bullet: player projectile with edge-triggered launch, per-frame flight, one-frame boss hit and cooldown
// Ports: frame_clk/Reset (async, active-high); menu/game_over sync abort; fire button level;
//        PlayerX/Y/S and direction give the launch point; BossX/Y/S give the hit window;
//        bulletX/Y/S feed the boss block; bullet_active, hit_pulse and shots_fired report status.
module player_bullet #(
  parameter int SPEED       = 8,
  parameter int COOLDOWN    = 20,
  parameter int BULLET_SIZE = 2,
  parameter int OFFSCREEN_X = 700,
  parameter int LEVEL_X_MIN = 1,
  parameter int LEVEL_X_MAX = 639,
  parameter int Y_MARGIN    = 30
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       menu,
  input  logic       game_over,
  input  logic       fire,
  input  logic [9:0] PlayerX,
  input  logic [9:0] PlayerY,
  input  logic [9:0] PlayerS,
  input  logic       direction,
  input  logic [9:0] BossX,
  input  logic [9:0] BossY,
  input  logic [9:0] BossS,
  output logic [9:0] bulletX,
  output logic [9:0] bulletY,
  output logic [9:0] bulletS,
  output logic       bullet_active,
  output logic       hit_pulse,
  output logic [7:0] shots_fired
);
  localparam int CW = $clog2(COOLDOWN + 1);
  localparam logic signed [11:0] SPD  = 12'(SPEED);
  localparam logic signed [11:0] XMIN = 12'(LEVEL_X_MIN);
  localparam logic signed [11:0] XMAX = 12'(LEVEL_X_MAX);
  localparam logic signed [11:0] YM   = 12'(Y_MARGIN);
  localparam logic [9:0] OFF_X = 10'(OFFSCREEN_X);
  typedef enum logic [1:0] {S_IDLE, S_FLY, S_HIT, S_COOL} state_t;
  state_t state, state_n;
  logic [9:0] x_n, y_n;
  logic [7:0] shots_n;
  logic [CW-1:0] cd_cnt, cd_n;
  logic fire_q, dir_q, dir_n, launch_req, abort;
  logic launch_hit, fly_hit, launch_oob, fly_oob;
  // 12-bit signed copies keep PlayerX+PlayerS and edge-crossing steps from wrapping
  logic signed [11:0] px, ps, py, bx, by, bs, cur_x, cur_y, launch_x, fly_x;
  function automatic logic in_window(input logic signed [11:0] x, y, cx, cy, s);
    return (x - cx <= s) && (cx - x <= s) && (y >= cy - s - YM) && (y <= cy + s + YM);
  endfunction
  assign px = {2'b00, PlayerX};
  assign ps = {2'b00, PlayerS};
  assign py = {2'b00, PlayerY};
  assign bx = {2'b00, BossX};
  assign by = {2'b00, BossY};
  assign bs = {2'b00, BossS};
  assign cur_x = {2'b00, bulletX};
  assign cur_y = {2'b00, bulletY};
  assign launch_x = direction ? px + ps : px - ps;
  assign fly_x = dir_q ? cur_x + SPD : cur_x - SPD;
  assign launch_oob = launch_x < XMIN || launch_x > XMAX;
  assign fly_oob = fly_x < XMIN || fly_x > XMAX;
  assign launch_hit = in_window(launch_x, py, bx, by, bs);
  assign fly_hit = in_window(fly_x, cur_y, bx, by, bs);
  assign launch_req = fire & ~fire_q;
  assign abort = menu | game_over;
  assign bulletS = 10'(BULLET_SIZE);
  assign bullet_active = state == S_FLY || state == S_HIT;
  assign hit_pulse = state == S_HIT;
  always_comb begin
    state_n = state;
    x_n = bulletX;
    y_n = bulletY;
    cd_n = cd_cnt;
    dir_n = dir_q;
    shots_n = shots_fired;
    unique case (state)
      S_IDLE: if (launch_req) begin
        dir_n = direction;
        y_n = PlayerY;
        shots_n = shots_fired + 8'd1;
        state_n = launch_oob ? S_COOL : launch_hit ? S_HIT : S_FLY;
        x_n = launch_oob ? OFF_X : launch_x[9:0];
        cd_n = CW'(COOLDOWN - 1);
      end
      // edge exit is tested first so it wins over a same-frame overlap
      S_FLY: begin
        state_n = fly_oob ? S_COOL : fly_hit ? S_HIT : S_FLY;
        x_n = fly_oob ? OFF_X : fly_x[9:0];
        cd_n = CW'(COOLDOWN - 1);
      end
      S_HIT: begin
        state_n = S_COOL;
        x_n = OFF_X;
        cd_n = CW'(COOLDOWN - 1);
      end
      default: begin
        state_n = cd_cnt == '0 ? S_IDLE : S_COOL;
        cd_n = cd_cnt == '0 ? cd_cnt : cd_cnt - CW'(1);
      end
    endcase
    if (abort) begin
      state_n = S_IDLE;
      x_n = OFF_X;
      y_n = '0;
      cd_n = '0;
      dir_n = 1'b1;
      shots_n = shots_fired;
    end
  end
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) begin
      state <= S_IDLE;
      bulletX <= OFF_X;
      bulletY <= '0;
      cd_cnt <= '0;
      fire_q <= 1'b0;
      dir_q <= 1'b1;
      shots_fired <= '0;
    end else begin
      state <= state_n;
      bulletX <= x_n;
      bulletY <= y_n;
      cd_cnt <= cd_n;
      fire_q <= fire & ~abort;
      dir_q <= dir_n;
      shots_fired <= shots_n;
    end
endmodule
